// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: pointer arithmetic and full/empty decode shared by the FIFO controller
package sync_fifo_pkg;
    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned aw);
        return (p + 32'd1) & ((32'd1 << (aw + 1)) - 32'd1);
    endfunction
    function automatic logic is_empty(input logic [31:0] w, input logic [31:0] r, input int unsigned aw);
        return ((w ^ r) & ((32'd1 << (aw + 1)) - 32'd1)) == 32'd0;
    endfunction
    function automatic logic is_full(input logic [31:0] w, input logic [31:0] r, input int unsigned aw);
        logic [31:0] m;
        m = (32'd1 << aw) - 32'd1;
        return (((w ^ r) & m) == 32'd0) && ((((w ^ r) >> aw) & 32'd1) == 32'd1);
    endfunction
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: stream handshakes, RAM port and status bundle of the FIFO controller
interface sync_fifo_ctrl_if #(
    parameter int DW = 18,
    parameter int AW = 7
);
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_wen;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
    modport master (
        output clear, in_valid, in_data, out_ready, ram_rd_data,
        input  in_ready, out_valid, out_data, ram_wen, ram_wr_addr, ram_wr_data,
               ram_rd_addr, count, almost_full, almost_empty
    );
    modport slave (
        input  clear, in_valid, in_data, out_ready, ram_rd_data,
        output in_ready, out_valid, out_data, ram_wen, ram_wr_addr, ram_wr_data,
               ram_rd_addr, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: AW+1 bit wrapping FIFO pointer with increment and synchronous clear
module fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        inc_i,
    output logic [AW:0] ptr_o
);
    localparam int PW = AW + 1;
    logic [AW:0] ptr_q, ptr_d;
    // clear wins over increment; increment wraps through the MSB
    always_comb ptr_d = clear_i ? '0 : inc_i ? PW'(ptr_inc(32'(ptr_q), AW)) : ptr_q;
    // pointer register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    assign ptr_o = ptr_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, occupancy and handshake controller around a 0-clock-read two-port RAM
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DW        = 18,
    parameter int AW        = 7,
    parameter int AFULL_TH  = int'(depth(AW)) - 2,
    parameter int AEMPTY_TH = 2
) (
    input logic          clk,
    input logic          rst_n,
    sync_fifo_ctrl_if.slave bus
);
    localparam int PW = AW + 1;
    localparam logic [AW:0] AF = PW'(AFULL_TH);
    localparam logic [AW:0] AE = PW'(AEMPTY_TH);
    logic [AW:0] wr_ptr, rd_ptr, count_q, count_d;
    logic        full, empty, push, pop;
    // status and handshakes come from registered pointers only
    always_comb begin
        empty = is_empty(32'(wr_ptr), 32'(rd_ptr), AW);
        full  = is_full(32'(wr_ptr), 32'(rd_ptr), AW);
        push  = bus.in_valid & !full;
        pop   = bus.out_ready & !empty;
    end
    fifo_ptr #(.AW(AW)) u_wr_ptr (.clk(clk), .rst_n(rst_n), .clear_i(bus.clear), .inc_i(push), .ptr_o(wr_ptr));
    fifo_ptr #(.AW(AW)) u_rd_ptr (.clk(clk), .rst_n(rst_n), .clear_i(bus.clear), .inc_i(pop), .ptr_o(rd_ptr));
    // occupancy tracks pushes minus pops; flush zeroes it
    always_comb count_d = bus.clear ? '0 : (push & !pop) ? count_q + PW'(1) : (pop & !push) ? count_q - PW'(1) : count_q;
    // occupancy register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else count_q <= count_d;
    assign bus.in_ready     = !full;
    assign bus.out_valid    = !empty;
    assign bus.out_data     = bus.ram_rd_data;
    assign bus.ram_wen      = push & !bus.clear & rst_n;
    assign bus.ram_wr_addr  = wr_ptr[AW-1:0];
    assign bus.ram_wr_data  = bus.in_data;
    assign bus.ram_rd_addr  = rd_ptr[AW-1:0];
    assign bus.count        = count_q;
    assign bus.almost_full  = count_q >= AF;
    assign bus.almost_empty = count_q <= AE;
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Pointer, occupancy and handshake controller for a synchronous FIFO built around the team's two-port RAM with registered write and zero-clock (combinational) read. It converts an upstream valid/ready write stream and a downstream valid/ready read stream into RAM write-enable, write address and read address. It also reports fill level, almost-full and almost-empty, and supports a synchronous flush. The `sync_fifo` top instantiates this controller next to the RAM; the controller never holds payload data.

## Interface
Parameters:
- DW, 18, payload width in bits; passed through to the RAM.
- AW, 7, RAM address width; depth = 2**AW.
- AFULL_TH, 2**AW-2, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous and active-low.
- clear  in  1  synchronous flush; empties the FIFO on the next edge.
- in_valid  in  1  upstream has data.
- in_ready  out  1  FIFO can accept data.
- in_data  in  DW  upstream payload.
- out_valid  out  1  FIFO has data at head.
- out_ready  in  1  downstream accepts head.
- out_data  out  DW  head payload; equals ram_rd_data.
- ram_wen  out  1  RAM write enable.
- ram_wr_addr  out  AW  RAM write address.
- ram_wr_data  out  DW  RAM write data; equals in_data.
- ram_rd_addr  out  AW  RAM read address.
- ram_rd_data  in  DW  RAM combinational read data.
- count  out  AW+1  current occupancy, 0..2**AW.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.

## Operation
- Pointers: wr_ptr and rd_ptr, each AW+1 bits. The low AW bits form the address. The MSB is a wrap bit.
- empty when wr_ptr == rd_ptr.
- full when the low bits are equal and the MSBs differ.
- Combinational handshake signals:
  - in_ready = !full.
  - out_valid = !empty.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- RAM connections:
  - ram_wen = push & !clear.
  - ram_wr_addr = wr_ptr[AW-1:0].
  - ram_rd_addr = rd_ptr[AW-1:0].
- Pointer update: push increments wr_ptr and pop increments rd_ptr, both modulo 2**(AW+1).
- count is a registered counter:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Invariant: count == wr_ptr - rd_ptr, modulo 2**(AW+1).
- Simultaneous push and pop:
  - Legal whenever neither full nor empty.
  - When full, in_ready = 0, so only a pop occurs. There is no write-through into a slot being freed.
  - When empty, out_valid = 0, so only a push occurs. There is no bypass; data appears the cycle after it is written.
- clear has priority over push and pop:
  - Pointers and count go to 0.
  - ram_wen is forced low that cycle.
- No internal state machine beyond the pointers and count. No overflow or underflow is possible, because handshakes gate every update.

## Timing
- Reset values (async, rst_n low): wr_ptr = 0, rd_ptr = 0, count = 0.
- Outputs while in reset: in_ready = 1, out_valid = 0, almost_full = 0, almost_empty = 1, ram_wen = 0.
- Write-to-read latency: data pushed at edge N is presented on out_data with out_valid = 1 during cycle N+1. This covers the RAM write at edge N plus the combinational read.
- Pop: out_data changes to the next entry immediately after the edge that advances rd_ptr.
- in_ready, out_valid, almost_full and almost_empty are derived from registered state only. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Wrap-around: after 2**AW pushes the address returns to 0 and the MSB toggles. Full and empty decoding must remain correct indefinitely.
- Reset mid-operation: contents are discarded and the FIFO reports empty asynchronously. The RAM array itself is not cleared.

## Structure
- Package `sync_fifo_pkg`: holds the pointer-increment function and the full/empty decode function, both parameterised through AW arguments. It also holds a localparam-style DEPTH helper.
- One natural sub-module, `fifo_ptr`: an AW+1 bit pointer register with increment and clear inputs, instantiated twice (write and read).
- The RAM is not instantiated here. `sync_fifo` wires the ram_* ports to `ram2p_0clk`.

## Test plan
- Reset, then push 1 word (0x155): out_valid rises exactly one cycle later; out_data = 0x155; count = 1; almost_empty = 1.
- AW=3: push 8 words 0..7 with out_ready = 0. in_ready drops after the 8th; count = 8; almost_full asserted from count 6. A 9th in_valid is not written (ram_wen = 0).
- Full FIFO with in_valid = 1 and out_ready = 1 held: the first cycle pops only. Thereafter push and pop are sustained every cycle, with count constant at 7 and data order preserved.
- Stream 40 words through with AW=3 (5 wraps) under random valid/ready: the output sequence equals the input sequence, and count always equals pushes minus pops.
- clear asserted while count = 5 together with push: next cycle count = 0, out_valid = 0, ram_wen was 0 during the clear cycle.
- rst_n pulsed low asynchronously mid-stream (between edges): out_valid drops immediately; after release the first new push is read back correctly at address 0.
